code_entry_buffer: RTL and testbench
====================================

CODE_ENTRY_BUFFER -- requirements
Module: code_entry_buffer

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: maximum digits held.
REQ-002 SHALL have parameter VALUE_W, default 32: width of typed/code_out; SHALL satisfy 10^NUM_DIGITS-1 < 2^VALUE_W.
REQ-003 SHALL have parameter DIGIT_MIN, default 1: lowest accepted digit key code.
REQ-004 SHALL have parameter DIGIT_MAX, default 6: highest accepted digit key code.
REQ-005 SHALL have parameter KEY_BS, default 8'd11: backspace key code.
REQ-006 SHALL have parameter KEY_ENTER, default 8'd12: enter key code.
REQ-007 SHALL have parameter TIMEOUT_CYCLES, default 24'd12_000_000: idle cycles before auto-clear; 0 disables timeout.
REQ-008 SHALL have ports:
  hwclk  in  1  single clock, all logic on rising edge
  reset  in  1  synchronous, active-high
  enable  in  1  entry allowed; low clears buffer
  button_pressed  in  1  keypad press level
  key  in  8  key code, valid while button_pressed high
  typed  out  VALUE_W  decimal value of digits entered so far
  digit_count  out  $clog2(NUM_DIGITS+1)  digits held
  full  out  1  digit_count == NUM_DIGITS
  code_out  out  VALUE_W  value latched at last enter
  entered  out  1  one-cycle pulse, code_out updated
  reject  out  1  one-cycle pulse, press ignored
  timeout  out  1  one-cycle pulse, buffer auto-cleared

Function
REQ-009 SHALL register button_pressed every cycle regardless of enable; press event = button_pressed & !prev & enable; held button SHALL produce one event only.
REQ-010 Digit event (DIGIT_MIN <= key <= DIGIT_MAX) with digit_count < NUM_DIGITS SHALL, next edge: typed <= typed*10 + key, digit_count +1.
REQ-011 Digit event when full SHALL leave typed/digit_count unchanged and pulse reject.
REQ-012 KEY_BS event with digit_count > 0 SHALL set typed <= typed/10 (integer), digit_count -1; with digit_count == 0 SHALL pulse reject, no change.
REQ-013 KEY_ENTER event with digit_count > 0 SHALL, next edge: code_out <= typed, entered = 1 for one cycle, typed <= 0, digit_count <= 0.
REQ-014 KEY_ENTER event with digit_count == 0 SHALL pulse reject; code_out unchanged, entered stays 0.
REQ-015 Any other key code event SHALL pulse reject, no state change.
REQ-016 Idle counter SHALL reset to 0 on every press event and whenever digit_count == 0, and SHALL increment each cycle otherwise.
REQ-017 When idle counter reaches TIMEOUT_CYCLES-1 with digit_count > 0 and no press event that cycle, next edge SHALL clear typed and digit_count, pulse timeout; code_out unchanged.
REQ-018 Press event in the expiry cycle SHALL win: press processed, no timeout, idle counter restarts.
REQ-019 enable low SHALL clear typed, digit_count, idle counter next edge; code_out retained; no pulses.
REQ-020 Priority: reset > !enable > press event > timeout.
REQ-021 entered, reject, timeout SHALL be registered, mutually exclusive, each high exactly one cycle per cause.
REQ-022 full SHALL be combinational from digit_count; all other outputs registered.
REQ-023 Event-to-output latency SHALL be 1 cycle.

Reset
REQ-024 reset high at an edge SHALL set typed, digit_count, code_out, idle counter, prev button to 0 and entered, reject, timeout to 0; full = 0.
REQ-025 reset mid-entry SHALL discard partial digits; first press after release SHALL need a fresh rising edge of button_pressed.

Verification
REQ-026 Defaults, press 3,5,2,4 then ENTER -> typed 3,35,352,3524; full after 4th; entered one cycle, code_out = 3524, typed = 0.
REQ-027 Press 1,2,3,4,5 -> 5th pulses reject, typed stays 1234; BS -> typed 123, digit_count 3.
REQ-028 Hold button_pressed 10 cycles with key 2 -> typed 2 exactly; key 7, 9 or 0 -> reject, typed unchanged.
REQ-029 TIMEOUT_CYCLES=16, press 4, idle -> timeout pulse, typed 0 on cycle 16 after press; repeat with press on expiry cycle -> no timeout, typed 4*10+digit.
REQ-030 Enter 56 to code_out, type 1, drop enable -> typed 0, digit_count 0, code_out 56; ENTER and BS on empty buffer -> reject each, no entered.
REQ-031 reset asserted with digit_count 3 while button held -> all outputs 0; no event until button released and pressed again.

Source files
------------

// File: rtl/code_entry_buffer.sv
// Keypad code entry buffer: collects decimal digits from a keypad, supports
// backspace and enter, and auto-clears a partial entry after an idle period.
module code_entry_buffer #(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned VALUE_W        = 32,
    parameter logic [7:0]  DIGIT_MIN      = 8'd1,
    parameter logic [7:0]  DIGIT_MAX      = 8'd6,
    parameter logic [7:0]  KEY_BS         = 8'd11,
    parameter logic [7:0]  KEY_ENTER      = 8'd12,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_000_000
) (
    input  logic                              hwclk,
    input  logic                              reset,
    input  logic                              enable,
    input  logic                              button_pressed,
    input  logic [7:0]                        key,
    output logic [VALUE_W-1:0]                typed,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_count,
    output logic                              full,
    output logic [VALUE_W-1:0]                code_out,
    output logic                              entered,
    output logic                              reject,
    output logic                              timeout
);

    localparam int unsigned CntW = $clog2(NUM_DIGITS + 1);
    localparam logic [CntW-1:0] MaxCount = CntW'(NUM_DIGITS);

    logic [VALUE_W-1:0] typed_q, typed_d;
    logic [CntW-1:0]    count_q, count_d;
    logic [VALUE_W-1:0] code_q, code_d;
    logic [23:0]        idle_q, idle_d;
    logic               entered_q, entered_d;
    logic               reject_q, reject_d;
    logic               timeout_q, timeout_d;
    logic               prev_q;
    // Set when reset sees the button held, so a press that straddles reset
    // needs a release before it can count.
    logic               block_q;

    logic press;
    logic is_digit;
    logic expire;

    assign press    = button_pressed & ~prev_q & ~block_q & enable;
    assign is_digit = (key >= DIGIT_MIN) && (key <= DIGIT_MAX);
    assign expire   = (TIMEOUT_CYCLES != 24'd0) && (idle_q == TIMEOUT_CYCLES - 24'd1) &&
                      (count_q != '0);

    // Next-state: priority is !enable > press event > timeout > idle counting.
    always_comb begin
        typed_d   = typed_q;
        count_d   = count_q;
        code_d    = code_q;
        idle_d    = idle_q;
        entered_d = 1'b0;
        reject_d  = 1'b0;
        timeout_d = 1'b0;
        if (!enable) begin
            typed_d = '0;
            count_d = '0;
            idle_d  = '0;
        end else if (press) begin
            idle_d = '0;
            if (is_digit) begin
                if (count_q < MaxCount) begin
                    typed_d = typed_q * VALUE_W'(10) + VALUE_W'(key);
                    count_d = count_q + CntW'(1);
                end else begin
                    reject_d = 1'b1;
                end
            end else if (key == KEY_BS) begin
                if (count_q != '0) begin
                    typed_d = typed_q / VALUE_W'(10);
                    count_d = count_q - CntW'(1);
                end else begin
                    reject_d = 1'b1;
                end
            end else if (key == KEY_ENTER) begin
                if (count_q != '0) begin
                    code_d    = typed_q;
                    entered_d = 1'b1;
                    typed_d   = '0;
                    count_d   = '0;
                end else begin
                    reject_d = 1'b1;
                end
            end else begin
                reject_d = 1'b1;
            end
        end else if (expire) begin
            typed_d   = '0;
            count_d   = '0;
            idle_d    = '0;
            timeout_d = 1'b1;
        end else if (count_q == '0) begin
            idle_d = '0;
        end else begin
            idle_d = idle_q + 24'd1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge hwclk) begin
        if (reset) begin
            typed_q   <= '0;
            count_q   <= '0;
            code_q    <= '0;
            idle_q    <= '0;
            entered_q <= 1'b0;
            reject_q  <= 1'b0;
            timeout_q <= 1'b0;
            prev_q    <= 1'b0;
            block_q   <= button_pressed;
        end else begin
            typed_q   <= typed_d;
            count_q   <= count_d;
            code_q    <= code_d;
            idle_q    <= idle_d;
            entered_q <= entered_d;
            reject_q  <= reject_d;
            timeout_q <= timeout_d;
            prev_q    <= button_pressed;
            block_q   <= block_q & button_pressed;
        end
    end

    assign typed       = typed_q;
    assign digit_count = count_q;
    assign full        = (count_q == MaxCount);
    assign code_out    = code_q;
    assign entered     = entered_q;
    assign reject      = reject_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_code_entry_buffer.sv
// Directed bench for code_entry_buffer with a short timeout of 16 cycles.
module tb_code_entry_buffer;

    logic        hwclk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b1;
    logic        button_pressed = 1'b0;
    logic [7:0]  key = 8'd0;
    logic [31:0] typed;
    logic [2:0]  digit_count;
    logic        full;
    logic [31:0] code_out;
    logic        entered;
    logic        reject;
    logic        timeout;

    int tests_run = 0;
    int tests_failed = 0;

    code_entry_buffer #(
        .TIMEOUT_CYCLES(24'd16)
    ) dut (
        .hwclk         (hwclk),
        .reset         (reset),
        .enable        (enable),
        .button_pressed(button_pressed),
        .key           (key),
        .typed         (typed),
        .digit_count   (digit_count),
        .full          (full),
        .code_out      (code_out),
        .entered       (entered),
        .reject        (reject),
        .timeout       (timeout)
    );

    always #5 hwclk = ~hwclk;

    // Press a key for one edge, then release at the following negedge.
    // Registered outputs stay valid until the next rising edge.
    task automatic press(input logic [7:0] k);
        @(negedge hwclk);
        key = k;
        button_pressed = 1'b1;
        @(posedge hwclk);
        #1;
        @(negedge hwclk);
        button_pressed = 1'b0;
    endtask

    task automatic clear_buf();
        @(negedge hwclk);
        enable = 1'b0;
        @(posedge hwclk);
        @(negedge hwclk);
        enable = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge hwclk);
        reset = 1'b1;
        repeat (2) @(posedge hwclk);
        #1;
        tests_run++;
        if ({typed, code_out} !== 64'd0 || digit_count !== 3'd0 || full !== 1'b0 ||
            {entered, reject, timeout} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset: typed=%0d cnt=%0d code=%0d full=%b pulses=%b%b%b want all 0",
                     typed, digit_count, code_out, full, entered, reject, timeout);
        end
        @(negedge hwclk);
        reset = 1'b0;
    endtask

    task automatic test_entry();
        logic [31:0] exp_v [4];
        logic [7:0]  digs [4];
        exp_v = '{32'd3, 32'd35, 32'd352, 32'd3524};
        digs  = '{8'd3, 8'd5, 8'd2, 8'd4};
        for (int i = 0; i < 4; i++) begin
            press(digs[i]);
            tests_run++;
            if (typed !== exp_v[i] || digit_count !== 3'(i + 1) || full !== (i == 3)) begin
                tests_failed++;
                $display("FAIL entry_digit%0d: typed=%0d cnt=%0d full=%b want %0d %0d %b",
                         i, typed, digit_count, full, exp_v[i], i + 1, i == 3);
            end
        end
        press(8'd12);
        tests_run++;
        if (entered !== 1'b1 || code_out !== 32'd3524 || typed !== 32'd0 ||
            digit_count !== 3'd0 || reject !== 1'b0) begin
            tests_failed++;
            $display("FAIL entry_enter: entered=%b code=%0d typed=%0d cnt=%0d want 1 3524 0 0",
                     entered, code_out, typed, digit_count);
        end
        @(posedge hwclk);
        #1;
        tests_run++;
        if (entered !== 1'b0) begin
            tests_failed++;
            $display("FAIL entry_pulse_width: entered=%b want 0", entered);
        end
    endtask

    task automatic test_overflow_bs();
        for (int i = 1; i <= 4; i++) press(8'(i));
        press(8'd5);
        tests_run++;
        if (reject !== 1'b1 || typed !== 32'd1234 || digit_count !== 3'd4) begin
            tests_failed++;
            $display("FAIL overflow: reject=%b typed=%0d cnt=%0d want 1 1234 4",
                     reject, typed, digit_count);
        end
        press(8'd11);
        tests_run++;
        if (reject !== 1'b0 || typed !== 32'd123 || digit_count !== 3'd3 || full !== 1'b0) begin
            tests_failed++;
            $display("FAIL backspace: reject=%b typed=%0d cnt=%0d full=%b want 0 123 3 0",
                     reject, typed, digit_count, full);
        end
        clear_buf();
    endtask

    task automatic test_hold_invalid();
        logic [7:0] bad [3];
        bad = '{8'd7, 8'd9, 8'd0};
        @(negedge hwclk);
        key = 8'd2;
        button_pressed = 1'b1;
        repeat (10) @(posedge hwclk);
        #1;
        tests_run++;
        if (typed !== 32'd2 || digit_count !== 3'd1) begin
            tests_failed++;
            $display("FAIL hold: typed=%0d cnt=%0d want 2 1", typed, digit_count);
        end
        @(negedge hwclk);
        button_pressed = 1'b0;
        for (int i = 0; i < 3; i++) begin
            press(bad[i]);
            tests_run++;
            if (reject !== 1'b1 || typed !== 32'd2 || digit_count !== 3'd1) begin
                tests_failed++;
                $display("FAIL invalid_key%0d: reject=%b typed=%0d cnt=%0d want 1 2 1",
                         bad[i], reject, typed, digit_count);
            end
        end
        clear_buf();
    endtask

    task automatic test_timeout();
        press(8'd4);
        repeat (15) @(posedge hwclk);
        #1;
        tests_run++;
        if (timeout !== 1'b0 || typed !== 32'd4) begin
            tests_failed++;
            $display("FAIL timeout_early: timeout=%b typed=%0d want 0 4", timeout, typed);
        end
        @(posedge hwclk);
        #1;
        tests_run++;
        if (timeout !== 1'b1 || typed !== 32'd0 || digit_count !== 3'd0 ||
            code_out !== 32'd3524) begin
            tests_failed++;
            $display("FAIL timeout_fire: timeout=%b typed=%0d cnt=%0d code=%0d want 1 0 0 3524",
                     timeout, typed, digit_count, code_out);
        end
        @(posedge hwclk);
        #1;
        tests_run++;
        if (timeout !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_pulse_width: timeout=%b want 0", timeout);
        end
        // Press lands exactly in the expiry cycle and must win.
        press(8'd4);
        repeat (15) @(posedge hwclk);
        press(8'd3);
        tests_run++;
        if (timeout !== 1'b0 || typed !== 32'd43 || digit_count !== 3'd2) begin
            tests_failed++;
            $display("FAIL timeout_press_wins: timeout=%b typed=%0d cnt=%0d want 0 43 2",
                     timeout, typed, digit_count);
        end
        clear_buf();
    endtask

    task automatic test_enable();
        press(8'd5);
        press(8'd6);
        press(8'd12);
        press(8'd1);
        tests_run++;
        if (code_out !== 32'd56 || typed !== 32'd1) begin
            tests_failed++;
            $display("FAIL enable_setup: code=%0d typed=%0d want 56 1", code_out, typed);
        end
        @(negedge hwclk);
        enable = 1'b0;
        @(posedge hwclk);
        #1;
        tests_run++;
        if (typed !== 32'd0 || digit_count !== 3'd0 || code_out !== 32'd56 ||
            {entered, reject, timeout} !== 3'b000) begin
            tests_failed++;
            $display("FAIL enable_low: typed=%0d cnt=%0d code=%0d pulses=%b%b%b want 0 0 56 000",
                     typed, digit_count, code_out, entered, reject, timeout);
        end
        @(negedge hwclk);
        enable = 1'b1;
        press(8'd12);
        tests_run++;
        if (reject !== 1'b1 || entered !== 1'b0 || code_out !== 32'd56) begin
            tests_failed++;
            $display("FAIL enter_empty: reject=%b entered=%b code=%0d want 1 0 56",
                     reject, entered, code_out);
        end
        press(8'd11);
        tests_run++;
        if (reject !== 1'b1 || entered !== 1'b0 || digit_count !== 3'd0) begin
            tests_failed++;
            $display("FAIL bs_empty: reject=%b entered=%b cnt=%0d want 1 0 0",
                     reject, entered, digit_count);
        end
    endtask

    task automatic test_reset_mid();
        press(8'd1);
        press(8'd2);
        press(8'd3);
        @(negedge hwclk);
        key = 8'd4;
        button_pressed = 1'b1;
        reset = 1'b1;
        @(posedge hwclk);
        #1;
        tests_run++;
        if ({typed, code_out} !== 64'd0 || digit_count !== 3'd0 ||
            {entered, reject, timeout, full} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_mid: typed=%0d cnt=%0d code=%0d want all 0",
                     typed, digit_count, code_out);
        end
        @(negedge hwclk);
        reset = 1'b0;
        repeat (3) @(posedge hwclk);
        #1;
        tests_run++;
        if (typed !== 32'd0 || digit_count !== 3'd0 || reject !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_held_button: typed=%0d cnt=%0d reject=%b want 0 0 0",
                     typed, digit_count, reject);
        end
        @(negedge hwclk);
        button_pressed = 1'b0;
        press(8'd4);
        tests_run++;
        if (typed !== 32'd4 || digit_count !== 3'd1) begin
            tests_failed++;
            $display("FAIL reset_fresh_press: typed=%0d cnt=%0d want 4 1", typed, digit_count);
        end
    endtask

    initial begin
        test_reset();
        test_entry();
        test_overflow_bs();
        test_hold_invalid();
        test_timeout();
        test_enable();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
